// File: rtl/divergence_ctrl.sv
// Turns decoded IF/ELSE/ENDIF into push/pop/comp pulses for the lane mask stack and tracks nesting depth.
// Optional macro DIVCTRL_FAST_ELSE_EN: single-pulse complement ELSE when the parent is the root mask.
`ifndef N_CORES
`define N_CORES 4
`endif
`ifndef STACK_DEPTH
`define STACK_DEPTH 3
`endif

module divergence_ctrl #(
    parameter int N_CORES     = `N_CORES,
    parameter int STACK_DEPTH = `STACK_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  logic [1:0]             instr_op,
    input  logic [N_CORES-1:0]     cond,
    output logic                   instr_ready,
    output logic [N_CORES-1:0]     stk_d_in,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic                   stk_comp,
    input  logic [N_CORES-1:0]     stk_tos,
    input  logic                   stk_all_false,
    output logic [N_CORES-1:0]     lane_en,
    output logic                   skip,
    output logic [STACK_DEPTH-1:0] depth,
    output logic                   overflow_err,
    output logic                   underflow_err
);

    typedef enum logic [1:0] {IDLE, CMD, ELSE_PUSH} state_t;

    localparam logic [STACK_DEPTH-1:0] DEPTH_MAX = '1;
    localparam logic [STACK_DEPTH-1:0] DEPTH_ONE = STACK_DEPTH'(1);

    state_t               state, state_nxt;
    logic                 accept;
    logic                 is_if, is_else, is_endif;
    logic                 if_ok, else_ok, endif_ok, else_fast;
    logic                 push_q, pop_q, else_pend_q;
    logic [N_CORES-1:0]   d_in_q, taken_q;

    always_comb begin
        accept    = instr_valid && (state == IDLE);
        is_if     = accept && (instr_op == 2'b01);
        is_else   = accept && (instr_op == 2'b10);
        is_endif  = accept && (instr_op == 2'b11);
        if_ok     = is_if && (depth != DEPTH_MAX);
        else_ok   = is_else && (depth != '0);
        endif_ok  = is_endif && (depth != '0);
`ifdef DIVCTRL_FAST_ELSE_EN
        else_fast = else_ok && (depth == DEPTH_ONE);
`else
        else_fast = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (if_ok || else_ok || endif_ok) state_nxt = CMD;
            CMD:       state_nxt = else_pend_q ? ELSE_PUSH : IDLE;
            ELSE_PUSH: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            push_q        <= 1'b0;
            pop_q         <= 1'b0;
            else_pend_q   <= 1'b0;
            d_in_q        <= '0;
            taken_q       <= '0;
            depth         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            push_q      <= if_ok;
            pop_q       <= endif_ok || (else_ok && !else_fast);
            else_pend_q <= else_ok && !else_fast;
            if (if_ok)
                d_in_q <= cond & stk_tos;
            if (else_ok)
                taken_q <= stk_tos;
            if (if_ok)
                depth <= depth + DEPTH_ONE;
            else if (endif_ok)
                depth <= depth - DEPTH_ONE;
            if (is_if && !if_ok)
                overflow_err <= 1'b1;
            if ((is_else && !else_ok) || (is_endif && !endif_ok))
                underflow_err <= 1'b1;
        end
    end

`ifdef DIVCTRL_FAST_ELSE_EN
    logic comp_q;
    always_ff @(posedge clk) begin
        if (reset)
            comp_q <= 1'b0;
        else
            comp_q <= else_fast;
    end
    assign stk_comp = comp_q;
`else
    assign stk_comp = 1'b0;
`endif

    // The ELSE push depends on the parent mask, only visible after the pop lands.
    assign stk_push    = push_q || (state == ELSE_PUSH);
    assign stk_d_in    = (state == ELSE_PUSH) ? (stk_tos & ~taken_q) : d_in_q;
    assign stk_pop     = pop_q;
    assign instr_ready = (state == IDLE);
    assign lane_en     = stk_tos;
    assign skip        = stk_all_false;

endmodule

// File: tb/tb_divergence_ctrl.sv
// Directed bench for divergence_ctrl with a behavioural mask stack on its stack port.
`ifndef N_CORES
`define N_CORES 4
`endif
`ifndef STACK_DEPTH
`define STACK_DEPTH 3
`endif

module tb_divergence_ctrl;

    localparam int N = `N_CORES;
    localparam int D = `STACK_DEPTH;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic [1:0]   instr_op = 2'b00;
    logic [N-1:0] cond = '0;
    logic         instr_ready;
    logic [N-1:0] stk_d_in;
    logic         stk_push, stk_pop, stk_comp;
    logic [N-1:0] stk_tos;
    logic         stk_all_false;
    logic [N-1:0] lane_en;
    logic         skip;
    logic [D-1:0] depth;
    logic         overflow_err, underflow_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divergence_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_op(instr_op),
        .cond(cond), .instr_ready(instr_ready), .stk_d_in(stk_d_in),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_comp(stk_comp),
        .stk_tos(stk_tos), .stk_all_false(stk_all_false), .lane_en(lane_en),
        .skip(skip), .depth(depth), .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    // Mask stack model: slot 0 holds the all-ones root.
    logic [N-1:0] mem [0:(1<<D)-1];
    int           sp;

    always_ff @(posedge clk) begin
        if (reset) begin
            sp     <= 0;
            mem[0] <= '1;
        end else if (stk_push) begin
            sp          <= sp + 1;
            mem[sp + 1] <= stk_d_in;
        end else if (stk_pop) begin
            sp <= sp - 1;
        end else if (stk_comp) begin
            mem[sp] <= mem[sp - 1] & ~mem[sp];
        end
    end
    assign stk_tos       = mem[sp];
    assign stk_all_false = (mem[sp] == '0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one instruction at a negedge; returns at the negedge of cycle t+1.
    task automatic send(input logic [1:0] op, input logic [N-1:0] c);
        int guard = 0;
        while (!instr_ready && guard < 10) begin
            step();
            guard++;
        end
        chk("send_rdy", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_op    = op;
        cond        = c;
        step();
        instr_valid = 1'b0;
        instr_op    = 2'b00;
        cond        = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic check_idle(input string tag, input logic [N-1:0] mask, input int dep);
        chk({tag, "_lane"}, 32'(lane_en), 32'(mask));
        chk({tag, "_depth"}, 32'(depth), 32'(dep));
        chk({tag, "_rdy"}, 32'(instr_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        do_reset();
        step();
        step();
        check_idle("rst", 4'b1111, 0);
        chk("rst_skip", 32'(skip), 32'd0);
        chk("rst_cmds", {29'd0, stk_push, stk_pop, stk_comp}, 32'd0);
        chk("rst_din", 32'(stk_d_in), 32'd0);
        chk("rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);

        // IF 0101 at depth 0
        send(2'b01, 4'b0101);
        chk("if1_push", 32'(stk_push), 32'd1);
        chk("if1_din", 32'(stk_d_in), 32'b0101);
        chk("if1_ready", 32'(instr_ready), 32'd0);
        step();
        check_idle("if1", 4'b0101, 1);
        chk("if1_push_off", 32'(stk_push), 32'd0);

        // ELSE at depth 1
        send(2'b10, 4'b0000);
`ifdef DIVCTRL_FAST_ELSE_EN
        chk("else1_comp", 32'(stk_comp), 32'd1);
        chk("else1_pop", 32'(stk_pop), 32'd0);
        step();
        check_idle("else1", 4'b1010, 1);
`else
        chk("else1_pop", 32'(stk_pop), 32'd1);
        chk("else1_comp", 32'(stk_comp), 32'd0);
        step();
        chk("else1_push", 32'(stk_push), 32'd1);
        chk("else1_din", 32'(stk_d_in), 32'b1010);
        chk("else1_ready", 32'(instr_ready), 32'd0);
        step();
        check_idle("else1", 4'b1010, 1);
`endif

        // ENDIF back to root
        send(2'b11, 4'b0000);
        chk("endif1_pop", 32'(stk_pop), 32'd1);
        chk("endif1_depth", 32'(depth), 32'd0);
        step();
        check_idle("endif1", 4'b1111, 0);

        // Op 00 is accepted with no command and no stall
        send(2'b00, 4'b1111);
        chk("nop_cmds", {29'd0, stk_push, stk_pop, stk_comp}, 32'd0);
        chk("nop_rdy", 32'(instr_ready), 32'd1);

        // Nested: IF 0011, IF 0100 -> empty mask
        send(2'b01, 4'b0011);
        step();
        check_idle("nest1", 4'b0011, 1);
        send(2'b01, 4'b0100);
        chk("nest2_din", 32'(stk_d_in), 32'b0000);
        step();
        check_idle("nest2", 4'b0000, 2);
        chk("nest2_skip", 32'(skip), 32'd1);
        send(2'b10, 4'b0000);
        chk("nest_else_pop", 32'(stk_pop), 32'd1);
        chk("nest_else_comp", 32'(stk_comp), 32'd0);
        step();
        chk("nest_else_push", 32'(stk_push), 32'd1);
        chk("nest_else_din", 32'(stk_d_in), 32'b0011);
        step();
        check_idle("nest_else", 4'b0011, 2);
        chk("nest_else_skip", 32'(skip), 32'd0);
        send(2'b11, 4'b0000);
        step();
        check_idle("nest_endif1", 4'b0011, 1);
        send(2'b11, 4'b0000);
        step();
        check_idle("nest_endif2", 4'b1111, 0);

        // Overflow: 7 IFs fill the stack, the 8th is refused
        for (int i = 0; i < 7; i++) begin
            send(2'b01, 4'b1111);
            step();
        end
        chk("full_depth", 32'(depth), 32'd7);
        chk("full_ovf", 32'(overflow_err), 32'd0);
        send(2'b01, 4'b1111);
        chk("ovf_flag", 32'(overflow_err), 32'd1);
        chk("ovf_push", 32'(stk_push), 32'd0);
        check_idle("ovf", 4'b1111, 7);
        step();
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // Underflow from reset
        do_reset();
        chk("rst2_ovf", 32'(overflow_err), 32'd0);
        send(2'b11, 4'b0000);
        chk("udf_flag", 32'(underflow_err), 32'd1);
        chk("udf_pop", 32'(stk_pop), 32'd0);
        check_idle("udf", 4'b1111, 0);

        // Reset landing in the ELSE_PUSH cycle of a depth-2 ELSE
        do_reset();
        send(2'b01, 4'b1111);
        step();
        send(2'b01, 4'b0110);
        step();
        chk("mid_depth", 32'(depth), 32'd2);
        send(2'b10, 4'b0000);
        chk("mid_pop", 32'(stk_pop), 32'd1);
        step();
        chk("mid_push", 32'(stk_push), 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_push", 32'(stk_push), 32'd0);
        chk("mid_rst_depth", 32'(depth), 32'd0);
        chk("mid_rst_rdy", 32'(instr_ready), 32'd1);
        chk("mid_rst_errs", {30'd0, overflow_err, underflow_err}, 32'd0);
        reset = 1'b0;
        step();
        step();
        check_idle("mid_after", 4'b1111, 0);
        chk("mid_after_cmds", {29'd0, stk_push, stk_pop, stk_comp}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
